// File: rtl/otter_intr_ctrl.sv
// OTTER interrupt controller: button sync/debounce, pending, mask,
// fixed priority and a request/taken/ack handshake with the CPU.
module otter_intr_ctrl #(
  parameter int NUM_SRC         = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ID_W            = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] btn_in,
  input  logic               intr_taken,
  input  logic               mmio_we,
  input  logic [1:0]         mmio_addr,
  input  logic [NUM_SRC-1:0] mmio_wdata,
  output logic [31:0]        mmio_rdata,
  output logic               intr,
  output logic [ID_W-1:0]    intr_id,
  output logic [NUM_SRC-1:0] btn_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  logic [NUM_SRC-1:0] sync1, sync2;
  logic [NUM_SRC-1:0] stable, stable_d;
  logic [CW-1:0]      cnt [NUM_SRC];
  logic [NUM_SRC-1:0] mask, pending, pend_nx;
  logic [NUM_SRC-1:0] pm, sel;
  logic [ID_W-1:0]    id, pri_id;
  state_t             state, state_nx;
  logic               wr_mask, wr_ack, wr_sw;
  logic               cur_pend, cur_mask, cur_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    wr_mask = 1'b0;
    wr_ack  = 1'b0;
    wr_sw   = 1'b0;
    if (mmio_we) begin
      unique case (1'b1)
        (mmio_addr == 2'd0): wr_mask = 1'b1;
        (mmio_addr == 2'd1): wr_ack  = 1'b1;
        (mmio_addr == 2'd2): wr_sw   = 1'b1;
        default: ;
      endcase
    end
  end

  // Set sources override a same-cycle ACK clear
  always_comb begin
    pend_nx = pending & ~(wr_ack ? mmio_wdata : '0);
    pend_nx = pend_nx | (stable & ~stable_d);
    pend_nx = pend_nx | (wr_sw ? mmio_wdata : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= '0;
      pending  <= '0;
      mask     <= '0;
    end else begin
      stable_d <= stable;
      pending  <= pend_nx;
      if (wr_mask) mask <= mmio_wdata;
    end
  end

  assign pm = pending & mask;

  always_comb begin
    pri_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pm[i]) pri_id = ID_W'(i);
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel[i] = (id == ID_W'(i));
    end
  end

  assign cur_pend = |(pending & sel);
  assign cur_mask = |(mask & sel);
  assign cur_ack  = wr_ack && |(mmio_wdata & sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      id    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |pm) id <= pri_id;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (|pm) state_nx = REQ;
      REQ: begin
        if (intr_taken) state_nx = SVC;
        else if (!cur_pend || !cur_mask) state_nx = IDLE;
      end
      SVC: if (cur_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    intr      = (state == REQ);
    intr_id   = id;
    btn_level = stable;
  end

  always_comb begin
    mmio_rdata = '0;
    unique case (mmio_addr)
      2'd0: mmio_rdata[NUM_SRC-1:0] = mask;
      2'd1: mmio_rdata[NUM_SRC-1:0] = pending;
      2'd2: begin
        mmio_rdata[9:8]      = state;
        mmio_rdata[ID_W-1:0] = id;
      end
      default: mmio_rdata = '0;
    endcase
  end

endmodule
